tdl_mc: RTL

Multi-channel, time-interleaved tapped delay line with an optional symmetric fold output. It keeps an independent TAPS-deep sample history for each of CHANNELS round-robin channels arriving on one input stream. On each accepted sample it presents the updated taps of that channel, plus the pairwise pre-added taps for linear-phase FIR MACs. It sits between the sample source and the FIR multiply-accumulate stage and replaces the single-channel delay line.

---
 rtl/tdl_mc_if.sv | 30 +++
 rtl/tdl_mc.sv | 113 +++++++++++
 2 files changed

// File: rtl/tdl_mc_if.sv
// rtl/tdl_mc_if.sv - sample stream and tap outputs of the multi-channel delay line
interface tdl_mc_if #(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8,
    parameter int CHANNELS   = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NF   = (TAPS + 1) / 2;

    logic                         VIN;
    logic signed [DATA_WIDTH-1:0] DIN;
    logic                         SYNC_IN;
    logic                         CLR;
    logic                         FOLD_EN;
    logic                         VOUT;
    logic [CH_W-1:0]              CH_OUT;
    logic                         PRIMED;
    logic signed [DATA_WIDTH-1:0] TP [0:TAPS-1];
    logic signed [DATA_WIDTH:0]   FP [0:NF-1];

    modport master (
        output VIN, DIN, SYNC_IN, CLR, FOLD_EN,
        input  VOUT, CH_OUT, PRIMED, TP, FP
    );

    modport slave (
        input  VIN, DIN, SYNC_IN, CLR, FOLD_EN,
        output VOUT, CH_OUT, PRIMED, TP, FP
    );
endinterface

// File: rtl/tdl_mc.sv
// rtl/tdl_mc.sv - time-interleaved per-channel tapped delay line with symmetric fold
module tdl_mc #(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8,
    parameter int CHANNELS   = 4
) (
    input  logic     CLK,
    input  logic     RST_n,
    tdl_mc_if.slave  bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NF     = (TAPS + 1) / 2;
    localparam int FILL_W = $clog2(TAPS + 1);

    typedef logic signed [DATA_WIDTH-1:0] smp_t;
    typedef logic signed [DATA_WIDTH:0]   fsmp_t;

    smp_t              line_q [0:CHANNELS-1][0:TAPS-1];
    logic [FILL_W-1:0] fill_q [0:CHANNELS-1];
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic [CH_W-1:0]   sel;
    logic [FILL_W-1:0] fill_d;
    logic              primed_d;
    smp_t              new_tap [0:TAPS-1];
    fsmp_t             fp_d [0:NF-1];

    logic              vout_q;
    logic [CH_W-1:0]   ch_q;
    logic              primed_q;
    smp_t              tp_q [0:TAPS-1];
    fsmp_t             fp_q [0:NF-1];

    // new_tap is the selected channel's history as it will look after this sample
    always_comb begin
        sel      = bus.SYNC_IN ? '0 : ptr_q;
        ptr_d    = (sel == CH_W'(CHANNELS - 1)) ? '0 : sel + CH_W'(1);
        fill_d   = (fill_q[sel] == FILL_W'(TAPS)) ? fill_q[sel] : fill_q[sel] + FILL_W'(1);
        primed_d = (fill_d == FILL_W'(TAPS));
        new_tap[0] = bus.DIN;
        for (int i = 1; i < TAPS; i++) begin
            new_tap[i] = line_q[sel][i-1];
        end
        for (int k = 0; k < NF; k++) begin
            fp_d[k] = '0;
        end
        if (bus.FOLD_EN) begin
            for (int k = 0; k < TAPS / 2; k++) begin
                fp_d[k] = fsmp_t'(new_tap[k]) + fsmp_t'(new_tap[TAPS-1-k]);
            end
            if (TAPS % 2 == 1) begin
                fp_d[NF-1] = fsmp_t'(new_tap[NF-1]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill_q[c] <= '0;
                for (int i = 0; i < TAPS; i++) begin
                    line_q[c][i] <= '0;
                end
            end
        end else if (bus.CLR) begin
            ptr_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill_q[c] <= '0;
                for (int i = 0; i < TAPS; i++) begin
                    line_q[c][i] <= '0;
                end
            end
        end else if (bus.VIN) begin
            ptr_q       <= ptr_d;
            fill_q[sel] <= fill_d;
            for (int i = 0; i < TAPS; i++) begin
                line_q[sel][i] <= new_tap[i];
            end
        end
    end

    // Presentation registers hold between samples and are only zeroed by reset or clear
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vout_q   <= 1'b0;
            ch_q     <= '0;
            primed_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) tp_q[i] <= '0;
            for (int k = 0; k < NF; k++)   fp_q[k] <= '0;
        end else if (bus.CLR) begin
            vout_q   <= 1'b0;
            ch_q     <= '0;
            primed_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) tp_q[i] <= '0;
            for (int k = 0; k < NF; k++)   fp_q[k] <= '0;
        end else if (bus.VIN) begin
            vout_q   <= 1'b1;
            ch_q     <= sel;
            primed_q <= primed_d;
            for (int i = 0; i < TAPS; i++) tp_q[i] <= new_tap[i];
            for (int k = 0; k < NF; k++)   fp_q[k] <= fp_d[k];
        end else begin
            vout_q <= 1'b0;
        end
    end

    assign bus.VOUT   = vout_q;
    assign bus.CH_OUT = ch_q;
    assign bus.PRIMED = primed_q;
    assign bus.TP     = tp_q;
    assign bus.FP     = fp_q;
endmodule
